// File: rtl/booth_divider.sv
// booth_divider: sequential signed divider, truncating quotient and remainder.
// Restoring shift-subtract on operand magnitudes, one quotient bit per clock,
// with a start/done handshake that matches the shift-add Booth multiplier.
// Optional build macro: DIV_ZERO_TRAP_EN. When defined, a zero divisor skips
// the iteration and returns a flagged trap result two edges after acceptance.
module booth_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, FIX_TRAP} state_t;

    state_t state, state_next;

    // The partial remainder never exceeds 2^(WIDTH-1) once stored (it is
    // either below the divisor magnitude or a prefix of the dividend
    // magnitude), so WIDTH bits hold it; the shifted trial value uses WIDTH+1.
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] qs;
    logic [WIDTH-1:0] dmag;
    logic [CW-1:0]    count;
    logic             qneg;
    logic             rneg;

    logic [WIDTH:0]   r_shift;
    logic             trial_ok;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] nmag_in;
    logic [WIDTH-1:0] dmag_in;

    // Magnitudes of the incoming operands; |-2^(WIDTH-1)| wraps to the
    // unsigned value 2^(WIDTH-1), which is exactly what the iteration needs.
    assign nmag_in = dividend[WIDTH-1] ? -dividend : dividend;
    assign dmag_in = divisor[WIDTH-1]  ? -divisor  : divisor;

    // One restoring step: shift in the next dividend bit and try to subtract.
    assign r_shift  = {r, qs[WIDTH-1]};
    assign trial_ok = (r_shift >= {1'b0, dmag});
    assign trial    = r_shift[WIDTH-1:0] - dmag;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unwritten,
        // which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_TRAP_EN
                    state_next = (divisor == '0) ? FIX_TRAP : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC:     if (count == CW'(1)) state_next = FIX;
            FIX:      state_next = IDLE;
            FIX_TRAP: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            r         <= '0;
            qs        <= '0;
            dmag      <= '0;
            count     <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dmag     <= dmag_in;
                        qs       <= nmag_in;
                        qneg     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rneg     <= dividend[WIDTH-1];
                        r        <= '0;
                        count    <= CW'(WIDTH);
                        busy     <= 1'b1;
                        overflow <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
                        div_by_zero <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    r     <= trial_ok ? trial : r_shift[WIDTH-1:0];
                    qs    <= {qs[WIDTH-2:0], trial_ok};
                    count <= count - CW'(1);
                end
                FIX: begin
                    quotient  <= qneg ? -qs : qs;
                    remainder <= rneg ? -r : r;
                    // Positive results cap at 2^(WIDTH-1)-1, negative at -2^(WIDTH-1).
                    overflow  <= qneg ? (qs[WIDTH-1] && (qs[WIDTH-2:0] != '0))
                                      : qs[WIDTH-1];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
`ifdef DIV_ZERO_TRAP_EN
                FIX_TRAP: begin
                    // qs still holds the dividend magnitude; restore its sign.
                    quotient    <= '1;
                    remainder   <= rneg ? -qs : qs;
                    overflow    <= 1'b0;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

`ifndef DIV_ZERO_TRAP_EN
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_booth_divider.sv
// tb_booth_divider: table-driven and randomized checks of booth_divider
// (WIDTH=8) against a plain-arithmetic reference model.
module tb_booth_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         overflow;
    logic         div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    booth_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         a;
        int         b;
        logic [7:0] q;
        logic [7:0] r;
        logic       ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: signed integer division truncates toward zero, % takes the
    // dividend's sign; a zero divisor follows the documented fallback.
    task automatic model(input int a, input int b, output logic [7:0] q,
                         output logic [7:0] r, output logic ov, output logic dz,
                         output int lat, output int bcyc);
        int qi;
        int ri;
        dz = 1'b0;
        if (b == 0) begin
`ifdef DIV_ZERO_TRAP_EN
            q = 8'hFF; ri = a; r = ri[7:0]; ov = 1'b0; dz = 1'b1;
            lat = 2; bcyc = 1;
`else
            qi = (a < 0) ? -255 : 255;
            q = qi[7:0]; ri = a; r = ri[7:0]; ov = 1'b1;
            lat = 10; bcyc = 9;
`endif
        end else begin
            qi = a / b;
            ri = a % b;
            q  = qi[7:0];
            r  = ri[7:0];
            ov = (qi > 127) || (qi < -128);
            lat = 10; bcyc = 9;
        end
    endtask

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
    endtask

    // Counts edges from the accepting edge (edge 1) until done is seen.
    // start is re-raised after edge `poke` (0 = never) to probe the busy guard.
    task automatic wait_done(input int poke, output int lat, output int bcyc);
        lat  = 0;
        bcyc = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start    = (poke != 0) && (lat == poke);
            dividend = 8'($urandom);
            divisor  = 8'($urandom_range(1, 255));
            if (busy && !done) bcyc++;
        end while (!done && lat < 40);
        start = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: done not seen after %0d edges", lat);
        end
    endtask

    task automatic run_check(input string tag, input int a, input int b, input int poke);
        logic [7:0] eq, er;
        logic       eov, edz;
        int         elat, ebc, lat, bc;
        model(a, b, eq, er, eov, edz, elat, ebc);
        launch(a[7:0], b[7:0]);
        wait_done(poke, lat, bc);
        check({tag, " quotient"},  32'(quotient),    32'(eq));
        check({tag, " remainder"}, 32'(remainder),   32'(er));
        check({tag, " overflow"},  32'(overflow),    32'(eov));
        check({tag, " div0"},      32'(div_by_zero), 32'(edz));
        check({tag, " latency"},   32'(lat),         32'(elat));
        check({tag, " busy"},      32'(bc),          32'(ebc));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " quotient"},  32'(quotient),    0);
        check({tag, " remainder"}, 32'(remainder),   0);
        check({tag, " busy"},      32'(busy),        0);
        check({tag, " done"},      32'(done),        0);
        check({tag, " overflow"},  32'(overflow),    0);
        check({tag, " div0"},      32'(div_by_zero), 0);
    endtask

    initial begin
        vec_t       tbl[12];
        logic [7:0] ra, rb;
        int         pulses;

        // Spec-derived expectations for WIDTH=8.
        tbl[0]  = '{100,   7, 8'h0E, 8'h02, 1'b0};
        tbl[1]  = '{-100,  7, 8'hF2, 8'hFE, 1'b0};
        tbl[2]  = '{100,  -7, 8'hF2, 8'h02, 1'b0};
        tbl[3]  = '{-100, -7, 8'h0E, 8'hFE, 1'b0};
        tbl[4]  = '{-10,  13, 8'h00, 8'hF6, 1'b0};
        tbl[5]  = '{-128, -1, 8'h80, 8'h00, 1'b1};
        tbl[6]  = '{-128,  1, 8'h80, 8'h00, 1'b0};
        tbl[7]  = '{127,   1, 8'h7F, 8'h00, 1'b0};
        tbl[8]  = '{-128, 127, 8'hFF, 8'hFF, 1'b0};
        tbl[9]  = '{-128, -128, 8'h01, 8'h00, 1'b0};
`ifdef DIV_ZERO_TRAP_EN
        tbl[10] = '{13,    0, 8'hFF, 8'h0D, 1'b0};
        tbl[11] = '{-13,   0, 8'hFF, 8'hF3, 1'b0};
`else
        tbl[10] = '{13,    0, 8'hFF, 8'h0D, 1'b1};
        tbl[11] = '{-13,   0, 8'h01, 8'hF3, 1'b1};
`endif

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Table: fixed expectations plus the model's latency/busy figures.
        for (int i = 0; i < 12; i++) begin
            logic [7:0] eq, er;
            logic       eov, edz;
            int         elat, ebc, lat, bc;
            model(tbl[i].a, tbl[i].b, eq, er, eov, edz, elat, ebc);
            launch(tbl[i].a[7:0], tbl[i].b[7:0]);
            wait_done(0, lat, bc);
            check($sformatf("tbl%0d quotient", i),  32'(quotient),  32'(tbl[i].q));
            check($sformatf("tbl%0d remainder", i), 32'(remainder), 32'(tbl[i].r));
            check($sformatf("tbl%0d overflow", i),  32'(overflow),  32'(tbl[i].ov));
            check($sformatf("tbl%0d div0", i),      32'(div_by_zero), 32'(edz));
            check($sformatf("tbl%0d latency", i),   32'(lat),       32'(elat));
            check($sformatf("tbl%0d busy", i),      32'(bc),        32'(ebc));
        end

        // start pulse at edge 4 of a busy operation is ignored.
        run_check("ignore", 100, 7, 3);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) pulses++;
        end
        check("ignore extra done", 32'(pulses), 0);
        check("ignore held quotient", 32'(quotient), 32'h0E);
        check("ignore held remainder", 32'(remainder), 32'h02);

        // Back-to-back: second start raised in the done cycle.
        run_check("b2b first", 50, -3, 0);
        run_check("b2b second", -77, 5, 0);

        // Reset at edge 5 of an operation aborts it without a done pulse.
        launch(8'd100, 8'd7);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("abort");
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort no done", 32'(pulses), 0);
        run_check("after abort", -100, -7, 0);

        // Randomized operands against the reference model.
        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            run_check($sformatf("rnd%0d %0d/%0d", i, $signed(ra), $signed(rb)),
                      int'($signed(ra)), int'($signed(rb)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
